// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared mode and direction types for the universal shift register
package shift_pkg;

    typedef enum logic [1:0] {
        SM_HOLD = 2'b00,
        SM_UP   = 2'b01,
        SM_DOWN = 2'b10,
        SM_LOAD = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

endpackage

// File: rtl/shift_frame_counter.sv
// rtl/shift_frame_counter.sv - counts same-direction shifts, pulses frame_done every WIDTH shifts
module shift_frame_counter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             shift_en,
    input  dir_t             dir,
    input  logic             load,
    output logic [CNT_W-1:0] count,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    dir_t             last_dir;
    dir_t             last_dir_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             done_nxt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count      <= '0;
            last_dir   <= DIR_NONE;
            frame_done <= 1'b0;
        end else begin
            count      <= count_nxt;
            last_dir   <= last_dir_nxt;
            frame_done <= done_nxt;
        end
    end

    // A direction change restarts the frame with this shift as its first;
    // completing a frame keeps last_dir so back-to-back frames run on.
    always_comb begin
        count_nxt    = count;
        last_dir_nxt = last_dir;
        done_nxt     = 1'b0;
        if (load) begin
            count_nxt    = '0;
            last_dir_nxt = DIR_NONE;
        end else if (shift_en) begin
            if (dir == last_dir) begin
                if (count == LAST) begin
                    count_nxt = '0;
                    done_nxt  = 1'b1;
                end else begin
                    count_nxt = count + ONE;
                end
            end else begin
                count_nxt    = ONE;
                last_dir_nxt = dir;
            end
        end
    end

endmodule

// File: rtl/param_universal_shift_reg.sv
// rtl/param_universal_shift_reg.sv - WIDTH-bit bidirectional shift register with parallel load and frame counter
module param_universal_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             E,
    input  logic [1:0]       mode,
    input  logic             sin_lo,
    input  logic             sin_hi,
    input  logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] Q,
    output logic             sout_hi,
    output logic             sout_lo,
    output logic [CNT_W-1:0] count,
    output logic             frame_done
);

    shift_mode_t mode_s;
    logic        shift_en;
    logic        load;
    dir_t        dir;

    assign mode_s   = shift_mode_t'(mode);
    assign shift_en = E && (mode_s == SM_UP || mode_s == SM_DOWN);
    assign load     = E && (mode_s == SM_LOAD);
    assign dir      = (mode_s == SM_UP)   ? DIR_UP :
                      (mode_s == SM_DOWN) ? DIR_DOWN : DIR_NONE;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            Q <= '0;
        end else if (E) begin
            case (mode_s)
                SM_UP:   Q <= {Q[WIDTH-2:0], sin_lo};
                SM_DOWN: Q <= {sin_hi, Q[WIDTH-1:1]};
                SM_LOAD: Q <= P;
                default: Q <= Q;
            endcase
        end
    end

    assign sout_hi = Q[WIDTH-1];
    assign sout_lo = Q[0];

    shift_frame_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_counter (
        .clk        (clk),
        .clr        (clr),
        .shift_en   (shift_en),
        .dir        (dir),
        .load       (load),
        .count      (count),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// tb/tb_param_universal_shift_reg.sv - self-checking bench for param_universal_shift_reg
module tb_param_universal_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          clr;
    logic          e;
    logic [1:0]    mode;
    logic          sin_lo;
    logic          sin_hi;
    logic [W-1:0]  p;
    logic [W-1:0]  q;
    logic          sout_hi;
    logic          sout_lo;
    logic [CW-1:0] count;
    logic          frame_done;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] m_q;
    int           m_cnt;
    int           m_dir;
    logic         m_fd;

    always #5 clk = ~clk;

    param_universal_shift_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .clr        (clr),
        .E          (e),
        .mode       (mode),
        .sin_lo     (sin_lo),
        .sin_hi     (sin_hi),
        .P          (p),
        .Q          (q),
        .sout_hi    (sout_hi),
        .sout_lo    (sout_lo),
        .count      (count),
        .frame_done (frame_done)
    );

    task automatic model_clear();
        m_q = '0; m_cnt = 0; m_dir = 0; m_fd = 1'b0;
    endtask

    task automatic apply(input logic en, input logic [1:0] md, input logic lo,
                         input logic hi, input logic [W-1:0] pd);
        e = en; mode = md; sin_lo = lo; sin_hi = hi; p = pd;
        m_fd = 1'b0;
        if (en) begin
            if (md == 2'b01 || md == 2'b10) begin
                if (md == 2'b01) m_q = (m_q << 1) | W'(lo);
                else             m_q = (m_q >> 1) | (W'(hi) << (W - 1));
                if (int'(md) == m_dir) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == W) begin
                        m_cnt = 0;
                        m_fd  = 1'b1;
                    end
                end else begin
                    m_cnt = 1;
                    m_dir = int'(md);
                end
            end else if (md == 2'b11) begin
                m_q = pd; m_cnt = 0; m_dir = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b0; e = 1'b0; mode = 2'b00; sin_lo = 1'b0; sin_hi = 1'b0; p = '0;
        model_clear();
        @(posedge clk);
        #1;
        total++;
        if ({q, count, frame_done} !== {W'(0), CW'(0), 1'b0})
            $display("FAIL reset_state: got Q=%h count=%0d fd=%b, want 0/0/0", q, count, frame_done);
        else passed++;
        clr = 1'b1;
    endtask

    task automatic test_async_reset();
        apply(1, 2'b11, 0, 0, 8'h14);
        apply(1, 2'b01, 1, 0, '0);
        apply(1, 2'b01, 0, 0, '0);
        apply(1, 2'b01, 1, 0, '0);
        total++;
        if ({q, count} !== {8'hA5, CW'(3)})
            $display("FAIL async_setup: got Q=%h count=%0d, want a5/3", q, count);
        else passed++;
        #2 clr = 1'b0;
        model_clear();
        #1;
        total++;
        if ({q, count, frame_done} !== {W'(0), CW'(0), 1'b0})
            $display("FAIL async_reset: got Q=%h count=%0d fd=%b, want 0/0/0", q, count, frame_done);
        else passed++;
        @(posedge clk);
        #1 clr = 1'b1;
    endtask

    task automatic test_shift_up();
        logic [7:0] seq = 8'b0011_1100;
        int pulses = 0;
        apply(1, 2'b11, 0, 0, 8'h3C);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (sout_hi !== seq[7-i])
                $display("FAIL up_sout_hi[%0d]: got %b, want %b", i, sout_hi, seq[7-i]);
            else passed++;
            apply(1, 2'b01, 1, 0, '0);
            if (frame_done) pulses++;
            total++;
            if ({q, count, frame_done} !== {m_q, CW'(m_cnt), m_fd})
                $display("FAIL up_step[%0d]: got Q=%h c=%0d fd=%b, want Q=%h c=%0d fd=%b",
                         i, q, count, frame_done, m_q, m_cnt, m_fd);
            else passed++;
        end
        total++;
        if ({q, count, frame_done, pulses} !== {8'hFF, CW'(0), 1'b1, 32'd1})
            $display("FAIL up_final: got Q=%h c=%0d fd=%b pulses=%0d, want ff/0/1/1",
                     q, count, frame_done, pulses);
        else passed++;
        apply(1, 2'b00, 0, 0, '0);
        total++;
        if (frame_done !== 1'b0)
            $display("FAIL up_pulse_width: got fd=%b, want 0", frame_done);
        else passed++;
    endtask

    task automatic test_shift_down();
        logic [7:0] seq = 8'b1000_0001;
        int pulses = 0;
        apply(1, 2'b11, 0, 0, 8'h81);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (sout_lo !== seq[7-i])
                $display("FAIL down_sout_lo[%0d]: got %b, want %b", i, sout_lo, seq[7-i]);
            else passed++;
            apply(1, 2'b10, 0, 0, '0);
            if (frame_done) pulses++;
        end
        total++;
        if ({q, count, pulses} !== {8'h00, CW'(0), 32'd1})
            $display("FAIL down_final: got Q=%h c=%0d pulses=%0d, want 00/0/1", q, count, pulses);
        else passed++;
    endtask

    task automatic test_dir_change();
        apply(1, 2'b11, 0, 0, 8'h5A);
        for (int i = 0; i < 5; i++) apply(1, 2'b01, 1'($urandom), 0, '0);
        apply(1, 2'b10, 0, 1'($urandom), '0);
        total++;
        if ({count, frame_done} !== {CW'(1), 1'b0})
            $display("FAIL dir_change_count: got c=%0d fd=%b, want 1/0", count, frame_done);
        else passed++;
        for (int i = 0; i < 7; i++) begin
            apply(1, 2'b10, 0, 1'($urandom), '0);
            total++;
            if ({q, count, frame_done} !== {m_q, CW'(m_cnt), (i == 6) ? 1'b1 : 1'b0})
                $display("FAIL dir_change_step[%0d]: got Q=%h c=%0d fd=%b, want Q=%h c=%0d fd=%b",
                         i, q, count, frame_done, m_q, m_cnt, (i == 6));
            else passed++;
        end
    endtask

    task automatic test_enable_gap();
        logic [W-1:0] q_hold;
        apply(1, 2'b11, 0, 0, 8'hC3);
        for (int i = 0; i < 3; i++) apply(1, 2'b01, 1'($urandom), 0, '0);
        q_hold = m_q;
        for (int i = 0; i < 3; i++) begin
            apply(0, 2'b01, i[0], 0, '0);
            total++;
            if ({q, count, frame_done} !== {q_hold, CW'(3), 1'b0})
                $display("FAIL enable_hold[%0d]: got Q=%h c=%0d fd=%b, want Q=%h c=3 fd=0",
                         i, q, count, frame_done, q_hold);
            else passed++;
        end
        for (int i = 0; i < 5; i++) begin
            apply(1, 2'b01, 1'($urandom), 0, '0);
            total++;
            if ({q, count, frame_done} !== {m_q, CW'(m_cnt), (i == 4) ? 1'b1 : 1'b0})
                $display("FAIL enable_resume[%0d]: got Q=%h c=%0d fd=%b, want Q=%h c=%0d fd=%b",
                         i, q, count, frame_done, m_q, m_cnt, (i == 4));
            else passed++;
        end
    endtask

    task automatic test_load_mid_frame();
        apply(1, 2'b11, 0, 0, 8'h0F);
        for (int i = 0; i < 6; i++) apply(1, 2'b10, 0, 1'($urandom), '0);
        total++;
        if (count !== CW'(6))
            $display("FAIL load_pre_count: got c=%0d, want 6", count);
        else passed++;
        apply(1, 2'b11, 0, 0, 8'hE7);
        total++;
        if ({q, count, frame_done} !== {8'hE7, CW'(0), 1'b0})
            $display("FAIL load_mid_frame: got Q=%h c=%0d fd=%b, want e7/0/0", q, count, frame_done);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            apply(1, 2'b10, 0, 1'($urandom), '0);
            total++;
            if ({q, count, frame_done} !== {m_q, CW'(m_cnt), (i == 7) ? 1'b1 : 1'b0})
                $display("FAIL load_fresh_frame[%0d]: got Q=%h c=%0d fd=%b, want Q=%h c=%0d fd=%b",
                         i, q, count, frame_done, m_q, m_cnt, (i == 7));
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        apply(1, 2'b11, 0, 0, 8'h00);
        for (int i = 1; i <= 16; i++) begin
            apply(1, 2'b01, 1'($urandom), 0, '0);
            total++;
            if (frame_done !== ((i % W) == 0))
                $display("FAIL back_to_back[%0d]: got fd=%b, want %b", i, frame_done, ((i % W) == 0));
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), W'($urandom));
            total++;
            if ({q, count, frame_done, sout_hi, sout_lo} !==
                {m_q, CW'(m_cnt), m_fd, m_q[W-1], m_q[0]})
                $display("FAIL random[%0d]: got Q=%h c=%0d fd=%b, want Q=%h c=%0d fd=%b",
                         i, q, count, frame_done, m_q, m_cnt, m_fd);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_shift_up();
        test_shift_down();
        test_dir_change();
        test_enable_gap();
        test_load_mid_frame();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
